uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART_TX_Top serializer between N byte-producing requesters.
- Accepts a byte and per-request parity configuration from the winning requester and launches it with a single-cycle Data_valid pulse.
- Holds the serializer inputs stable while the frame is sent, then reports completion to that requester.
- Sits directly in front of UART_TX_Top. Its P_Data/Data_valid/Par_EN/Par_type outputs drive the serializer, and the serializer's Busy feeds back in.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDW, 2, width of grant index; must equal ceil(log2(NUM_REQ)).
- TIMEOUT_CYCLES, 16, cycles to wait for Busy to rise after launch (used only with UART_ARB_TIMEOUT_EN).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request; held high with data until ack.
- req_data  in  NUM_REQ*8  byte per requester; requester i at bits [8i+7:8i].
- req_par_en  in  NUM_REQ  parity enable per requester.
- req_par_type  in  NUM_REQ  parity type per requester (0 even, 1 odd).
- ack  out  NUM_REQ  one-hot, one-cycle pulse: request accepted, data captured.
- done  out  NUM_REQ  one-hot, one-cycle pulse: that requester's frame fully transmitted.
- grant_id  out  IDW  index of the current owner; valid while arb_busy=1.
- arb_busy  out  1  high from acceptance until done.
- timeout_err  out  1  sticky error flag; tied 0 without the macro.
- P_Data  out  8  byte to serializer.
- Data_valid  out  1  one-cycle launch pulse to serializer.
- Par_EN  out  1  parity enable to serializer.
- Par_type  out  1  parity type to serializer.
- Busy  in  1  serializer busy.

Behaviour:
- All outputs are registered.
- Reset (RST=0, asynchronous):
  - all outputs, the FSM and the holding registers go to 0;
  - state=IDLE;
  - round-robin pointer = 0, i.e. requester 0 has highest priority.
  - Reset mid-frame aborts with no done pulse; the serializer is reset by the same RST.
- FSM states: IDLE, LAUNCH, WAIT_RISE, WAIT_FALL.
- IDLE:
  - If |req and Busy==0 at an edge, select the winner W:
    - W is the first asserted req scanning from ptr upward, wrapping modulo NUM_REQ.
    - Load P_Data/Par_EN/Par_type from W's inputs.
    - grant_id=W, arb_busy=1, goto LAUNCH.
  - If Busy==1 in IDLE, no grant is made.
- LAUNCH (exactly one cycle):
  - Data_valid=1 and ack[W]=1 during this cycle.
  - Next state is WAIT_RISE.
  - Latency: req sampled at edge k gives ack and Data_valid high in cycle k+1.
- WAIT_RISE:
  - Data_valid=0; wait for Busy==1, then goto WAIT_FALL.
  - If Busy is already 1 on the first WAIT_RISE edge, that counts as the rise.
- WAIT_FALL: on Busy==0:
  - done[W]=1 for one cycle;
  - arb_busy=0;
  - ptr=(W+1) mod NUM_REQ;
  - goto IDLE.
- P_Data/Par_EN/Par_type stay constant from LAUNCH until the done cycle. They change only at the next grant.
- Back-to-back transfers:
  - A grant may occur on the edge after done, earliest, since IDLE is visited for at least one cycle.
  - Inter-frame gap is therefore at least 2 cycles of Busy low.
- Request dropped after ack is ignored; the frame completes.
- Request dropped before ack is never granted.
- req changes during a frame have no effect until IDLE.
- Requests present in the same cycle are resolved purely by ptr. With all requesters holding req, grants cycle 0,1,2,3,0...
- ack and done are never high for two requesters at once.

Optional Feature:
- UART_ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT_RISE.
  - If Busy stays 0 for TIMEOUT_CYCLES cycles:
    - set timeout_err (sticky until reset);
    - pulse done[W];
    - ptr advances;
    - return to IDLE.
- Without the macro:
  - WAIT_RISE waits indefinitely;
  - no counter is instantiated;
  - timeout_err is constant 0.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding constants (IDLE=2'd0, LAUNCH=2'd1, WAIT_RISE=2'd2, WAIT_FALL=2'd3);
  - parity type constants PAR_EVEN=1'b0, PAR_ODD=1'b1;
  - frame widths FRAME_W_PAR=11, FRAME_W_NOPAR=10.
- Natural sub-module: rr_priority_picker.
  - Combinational.
  - Inputs: req vector, ptr. Outputs: winner index, any_valid.
  - Reusable by future RX-side schedulers.

Test Plan:
- Single request: req[2]=1, data 8'hA5, par_en=1, type even -> ack[2] and Data_valid coincide 1 cycle later. TX_OUT frame is 0,10100101 LSB-first, parity 0, stop 1 (11 bits). done[2] follows Busy fall.
- All four requesters held high with data 8'h01..8'h04 -> grants in order 0,1,2,3,0. Each done precedes the next Data_valid, and P_Data is stable during each Busy window.
- Busy forced high externally before req[1] -> no ack until Busy=0, then normal launch.
- Mixed parity: req[0] 8'h3C no parity, req[1] 8'h3C odd parity -> 10-bit then 11-bit frame; Par_EN/Par_type are correct for each.
- RST pulsed low in WAIT_FALL -> all outputs 0 asynchronously, no done, ptr=0. A subsequent simultaneous req[3]+req[0] grants 0 first.
- (UART_ARB_TIMEOUT_EN) Busy stubbed to 0 -> after 16 cycles in WAIT_RISE: timeout_err=1, done pulse, FSM returns to IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: arbiter FSM encoding, parity
// selection and frame lengths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_RISE = 2'd2,
    WAIT_FALL = 2'd3
  } arb_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int FRAME_W_PAR   = 11;
  localparam int FRAME_W_NOPAR = 10;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: returns the first asserted request at or
// above ptr, wrapping modulo NUM_REQ.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     winner,
  output logic               any_valid
);

  int             idx;
  logic [IDW-1:0] sel;

  // Scan from the farthest offset down so the nearest hit to ptr wins last.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = IDW'(idx);
      if (req[sel]) begin
        winner    = sel;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX_Top serializer among NUM_REQ requesters.
// Optional launch watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int IDW            = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_par_en,
  input  logic [NUM_REQ-1:0]   req_par_type,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   done,
  output logic [IDW-1:0]       grant_id,
  output logic                 arb_busy,
  output logic                 timeout_err,
  output logic [7:0]           P_Data,
  output logic                 Data_valid,
  output logic                 Par_EN,
  output logic                 Par_type,
  input  logic                 Busy
);

  arb_state_t     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] pick_w;
  logic           pick_vld;
  logic [IDW-1:0] next_ptr;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .req       (req),
    .ptr       (ptr),
    .winner    (pick_w),
    .any_valid (pick_vld)
  );

  assign next_ptr = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      ptr        <= '0;
      grant_id   <= '0;
      arb_busy   <= 1'b0;
      ack        <= '0;
      done       <= '0;
      P_Data     <= '0;
      Data_valid <= 1'b0;
      Par_EN     <= 1'b0;
      Par_type   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      ack        <= '0;
      done       <= '0;
      Data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld && !Busy) begin
            P_Data     <= req_data[{pick_w, 3'b000} +: 8];
            Par_EN     <= req_par_en[pick_w];
            Par_type   <= req_par_type[pick_w];
            grant_id   <= pick_w;
            arb_busy   <= 1'b1;
            ack        <= NUM_REQ'(1) << pick_w;
            Data_valid <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
`ifdef UART_ARB_TIMEOUT_EN
          to_cnt <= '0;
`endif
          state <= WAIT_RISE;
        end
        WAIT_RISE: begin
          if (Busy) begin
            state <= WAIT_FALL;
`ifdef UART_ARB_TIMEOUT_EN
          end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            // Serializer never started: release the owner so others are not starved.
            timeout_err <= 1'b1;
            done        <= NUM_REQ'(1) << grant_id;
            arb_busy    <= 1'b0;
            ptr         <= next_ptr;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
`endif
          end
        end
        WAIT_FALL: begin
          if (!Busy) begin
            done     <= NUM_REQ'(1) << grant_id;
            arb_busy <= 1'b0;
            ptr      <= next_ptr;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter; the bench plays the serializer by driving Busy.
// Covers the UART_ARB_TIMEOUT_EN build when that macro is defined.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 16;

  logic           CLK_tb = 1'b0;
  logic           RST;
  logic [N-1:0]   req;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_par_en;
  logic [N-1:0]   req_par_type;
  logic [N-1:0]   ack;
  logic [N-1:0]   done;
  logic [IDW-1:0] grant_id;
  logic           arb_busy;
  logic           timeout_err;
  logic [7:0]     P_Data;
  logic           Data_valid;
  logic           Par_EN;
  logic           Par_type;
  logic           Busy;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;   // model round-robin pointer

  uart_tx_arbiter #(.NUM_REQ(N), .IDW(IDW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK_tb), .RST(RST), .req(req), .req_data(req_data),
    .req_par_en(req_par_en), .req_par_type(req_par_type), .ack(ack), .done(done),
    .grant_id(grant_id), .arb_busy(arb_busy), .timeout_err(timeout_err),
    .P_Data(P_Data), .Data_valid(Data_valid), .Par_EN(Par_EN), .Par_type(Par_type),
    .Busy(Busy)
  );

  always #5 CLK_tb = ~CLK_tb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_tb);
    #1;
  endtask

  // Reference rule: first pending requester at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [7:0] d, input logic pe, input logic pt);
    req[i]              = 1'b1;
    req_data[8*i +: 8]  = d;
    req_par_en[i]       = pe;
    req_par_type[i]     = pt;
  endtask

  // One complete transfer: wait for launch, check it, emulate the serializer, check done.
  task automatic do_frame(input int bdelay, input bit hold, output int lat);
    int w, nbits;
    logic [7:0] d;
    logic pe, pt;
    logic [N-1:0] oh;
    bit seen;
    w = pick(req, mptr);
    lat = 0;
    seen = 0;
    if (w < 0) begin
      chk("model_has_req", 0, 1);
      return;
    end
    d  = req_data[8*w +: 8];
    pe = req_par_en[w];
    pt = req_par_type[w];
    oh = N'(1) << w;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      lat++;
      if (Data_valid) seen = 1;
      else chk("done_idle", done, 0);
    end
    chk("launch_seen", seen, 1);
    if (!seen) return;
    chk("ack_onehot", ack, oh);
    chk("grant_id", grant_id, w);
    chk("arb_busy_on", arb_busy, 1);
    chk("p_data", P_Data, d);
    chk("par_en", Par_EN, pe);
    chk("par_type", Par_type, pt);
    chk("done_at_ack", done, 0);
    if (!hold) req[w] = 1'b0;
    tick();
    chk("dv_pulse", Data_valid, 0);
    chk("ack_pulse", ack, 0);
    for (int b = 0; b < bdelay; b++) begin
      tick();
      chk("wait_rise_busy", arb_busy, 1);
    end
    Busy  = 1'b1;
    nbits = pe ? FRAME_W_PAR : FRAME_W_NOPAR;
    for (int b = 0; b < nbits; b++) begin
      tick();
      chk("p_data_hold", P_Data, d);
      chk("par_hold", {Par_EN, Par_type}, {pe, pt});
      chk("no_early_done", done, 0);
      chk("no_relaunch", Data_valid, 0);
    end
    Busy = 1'b0;
    tick();
    chk("done_onehot", done, oh);
    chk("arb_busy_off", arb_busy, 0);
    chk("p_data_after", P_Data, d);
    mptr = (w + 1) % N;
  endtask

  initial begin
    int lat;
    bit seen;
    RST = 1'b0; Busy = 1'b0;
    req = '0; req_data = '0; req_par_en = '0; req_par_type = '0;
    #1;
    chk("rst_outputs", {ack, done, grant_id, arb_busy, timeout_err, P_Data, Data_valid, Par_EN, Par_type}, 0);
    tick(); tick();
    RST = 1'b1;
    tick();
    chk("idle_no_req", {ack, Data_valid, arb_busy}, 0);

    // Single request, even parity
    set_req(2, 8'hA5, 1'b1, PAR_EVEN);
    do_frame(1, 0, lat);
    chk("single_latency", lat, 1);

    // All four held: fresh pointer gives 0,1,2,3,0 with minimum gap
    RST = 1'b0; #1; RST = 1'b1; mptr = 0;
    for (int i = 0; i < N; i++) set_req(i, 8'(i + 1), 1'b1, 1'(i));
    for (int k = 0; k < 5; k++) begin
      do_frame(0, 1, lat);
      chk("b2b_latency", lat, 1);
    end
    req = '0;
    tick();

    // Busy held externally blocks grant; a request withdrawn before ack is never served
    Busy = 1'b1;
    set_req(1, 8'h5A, 1'b0, PAR_EVEN);
    set_req(3, 8'hC3, 1'b1, PAR_ODD);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("busy_blocks", {ack, Data_valid, arb_busy}, 0);
      if (k == 1) req[3] = 1'b0;
    end
    Busy = 1'b0;
    do_frame(2, 0, lat);

    // Mixed parity with identical data
    set_req(0, 8'h3C, 1'b0, PAR_EVEN);
    set_req(1, 8'h3C, 1'b1, PAR_ODD);
    do_frame(0, 0, lat);
    do_frame(3, 0, lat);

    // Asynchronous reset while in WAIT_FALL
    set_req(2, 8'h77, 1'b1, PAR_ODD);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (Data_valid) seen = 1;
    end
    chk("rst_test_launch", seen, 1);
    req[2] = 1'b0;
    tick();
    Busy = 1'b1;
    tick(); tick();
    chk("pre_rst_busy", arb_busy, 1);
    #2;
    RST = 1'b0;
    #1;
    chk("async_rst_outputs", {ack, done, grant_id, arb_busy, P_Data, Data_valid, Par_EN, Par_type}, 0);
    Busy = 1'b0;
    tick();
    chk("rst_no_done", done, 0);
    RST = 1'b1;
    mptr = 0;
    set_req(3, 8'h33, 1'b0, PAR_EVEN);
    set_req(0, 8'h00, 1'b1, PAR_ODD);
    do_frame(0, 0, lat);
    do_frame(1, 0, lat);

    // Randomised traffic against the reference pointer model
    for (int it = 0; it < 24; it++) begin
      req = '0;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 1) == 1)
          set_req(i, 8'($urandom), 1'($urandom), 1'($urandom));
      if (req == '0) set_req(int'($urandom_range(0, N - 1)), 8'($urandom), 1'b1, 1'b0);
      do_frame(int'($urandom_range(0, 3)), 0, lat);
    end
    req = '0;
    tick();
    chk("final_done_clear", done, 0);

`ifdef UART_ARB_TIMEOUT_EN
    set_req(1, 8'h99, 1'b0, PAR_EVEN);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (Data_valid) seen = 1;
    end
    chk("to_launch", seen, 1);
    req[1] = 1'b0;
    for (int k = 0; k < TO; k++) begin
      tick();
      chk("to_no_done", done, 0);
    end
    tick();
    chk("to_done", done, N'(1) << 1);
    chk("to_err", timeout_err, 1);
    chk("to_release", arb_busy, 0);
    tick();
    chk("to_sticky", timeout_err, 1);
`else
    chk("timeout_tied", timeout_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
